// File: rtl/systolic_result_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : systolic_pkg
// Description : Shared defaults, index-width helper and stream FSM state
//               encoding for the systolic array and its result streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    // Defaults shared by the array, the streamer and their benches
    localparam int unsigned DEFAULT_N     = 4;
    localparam int unsigned DEFAULT_ACC_W = 11;

    // Width of a row or column index for an n x n matrix (never zero)
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/systolic_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Interface   : systolic_result_streamer_if
// Description : Valid/ready element stream leaving the result streamer.
//               master = streamer side, slave = downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_result_streamer_if
    import systolic_pkg::*;
#(
    parameter int unsigned ACC_W = DEFAULT_ACC_W
) ();

    logic [ACC_W-1:0] data_o;
    logic             valid_o;
    logic             ready_i;
    logic             last_o;

    modport master (output data_o, output valid_o, output last_o, input ready_i);
    modport slave  (input data_o, input valid_o, input last_o, output ready_i);

endinterface
`default_nettype wire

// File: rtl/systolic_result_streamer_rc_counter.sv
`default_nettype none
// ============================================================================
// Module      : rc_counter
// Description : Row-major row/col walker over an N x N matrix. Clear has
//               priority over advance; advancing past (N-1, N-1) wraps to
//               (0, 0). o_last flags the final element.
// Revision    : 1.0 - initial release
// ============================================================================
module rc_counter
    import systolic_pkg::*;
#(
    parameter int unsigned N     = DEFAULT_N,
    parameter int unsigned IDX_W = idx_width(N)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_advance,
    output logic [IDX_W-1:0]      o_row,
    output logic [IDX_W-1:0]      o_col,
    output logic                  o_last
);

    localparam logic [IDX_W-1:0] C_MAX = IDX_W'(N - 1);

    logic [IDX_W-1:0] r_row;
    logic [IDX_W-1:0] r_col;

    // Step through columns, carrying into the row at the end of each row
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            if (r_col == C_MAX) begin
                r_col <= '0;
                r_row <= (r_row == C_MAX) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == C_MAX) && (r_col == C_MAX);

endmodule
`default_nettype wire

// File: rtl/systolic_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : systolic_result_streamer
// Description : Snapshots the systolic array's N x N result on the rising
//               edge of done_i and streams it row-major, one element per
//               valid/ready handshake. A done edge landing on the final
//               handshake chains straight into the next matrix; any other
//               done edge while streaming is dropped and sets overrun_o.
//               Optional macro STREAM_INDEX_EN adds row_o/col_o outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_result_streamer
    import systolic_pkg::*;
#(
    parameter int unsigned N     = DEFAULT_N,
    parameter int unsigned ACC_W = DEFAULT_ACC_W
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_i,
    input  wire logic                   done_i,
    input  wire logic [N*N*ACC_W-1:0]   result_i,
    systolic_result_streamer_if.master  strm,
    output logic                        busy_o,
    output logic                        overrun_o
`ifdef STREAM_INDEX_EN
    ,
    output logic [$clog2(N)-1:0]        row_o,
    output logic [$clog2(N)-1:0]        col_o
`endif
);

    localparam int unsigned IDX_W    = idx_width(N);
    localparam int unsigned NUM_ELEM = N * N;
    localparam int unsigned SEL_W    = $clog2(NUM_ELEM);

    state_t           r_state;
    logic             r_done_q;
    logic             r_overrun;
    logic [ACC_W-1:0] r_snap [NUM_ELEM];

    logic [IDX_W-1:0] w_row;
    logic [IDX_W-1:0] w_col;
    logic [SEL_W-1:0] w_sel;
    logic             w_last_idx;
    logic             w_valid;
    logic             w_rise;
    logic             w_hs;
    logic             w_final_hs;
    logic             w_capture;

    assign w_valid    = (r_state == STREAM);
    assign w_rise     = done_i & ~r_done_q;
    assign w_hs       = w_valid & strm.ready_i;
    assign w_final_hs = w_hs & w_last_idx;
    // Accept a new matrix when idle, or exactly as the last element leaves
    assign w_capture  = w_rise & (~w_valid | w_final_hs);

    rc_counter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rc_counter (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_clear   (w_capture),
        .i_advance (w_hs),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last_idx)
    );

    // Control: done edge detector, IDLE/STREAM sequencing, sticky overrun
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_done_q  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done_q <= done_i;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_final_hs && !w_rise) begin
                        r_state <= IDLE;
                    end
                    if (w_rise && !w_final_hs) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Snapshot store; contents are only observed while streaming, so no reset
    always_ff @(posedge clk_i) begin
        if (w_capture) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                r_snap[i] <= result_i[i*ACC_W +: ACC_W];
            end
        end
    end

    assign w_sel = SEL_W'(w_row) * SEL_W'(N) + SEL_W'(w_col);

    assign strm.valid_o = w_valid;
    assign strm.data_o  = w_valid ? r_snap[w_sel] : '0;
    assign strm.last_o  = w_valid & w_last_idx;
    assign busy_o       = w_valid;
    assign overrun_o    = r_overrun;

`ifdef STREAM_INDEX_EN
    assign row_o = w_row;
    assign col_o = w_col;
`endif

endmodule
`default_nettype wire

// File: doc/systolic_result_streamer.md
Name: systolic_result_streamer

Overview:
Drains the N×N result matrix produced by the systolic array and emits it one element per handshake on a valid/ready stream, in row-major order. It is the read end of the array's result interface. It snapshots the array's parallel result outputs when done rises, then serializes them under downstream backpressure. The array is free to start the next multiplication while the snapshot is being streamed.

Parameters:
N, 4, matrix dimension (rows = cols); N >= 2.
ACC_W, 11, width of one result element; matches the array's result width.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_i  in  1  synchronous, active-high reset.
done_i  in  1  array done level; a rising edge marks result_i as valid.
result_i  in  N*N*ACC_W  flattened result matrix; element [r][c] at bits (r*N+c)*ACC_W +: ACC_W.
data_o  out  ACC_W  current streamed element.
valid_o  out  1  data_o is valid.
ready_i  in  1  downstream accepts when valid_o && ready_i.
last_o  out  1  high with element [N-1][N-1].
busy_o  out  1  snapshot held and not yet fully drained.
overrun_o  out  1  sticky; set when a done rising edge is dropped.

Behaviour:
- Reset (rst_i high at a clock edge): state=IDLE; valid_o=0, last_o=0, busy_o=0, overrun_o=0, data_o=0; done_q=0; row/col counters=0. Reset mid-stream abandons the snapshot. No element is emitted after reset.
- Edge detect: done_q <= done_i every cycle. done_rise = done_i & ~done_q. A done_i level held high produces exactly one capture.
- FSM states are IDLE and STREAM.
- IDLE, on done_rise:
  - snapshot_reg <= result_i; row=0, col=0; go to STREAM.
  - valid_o=1 and data_o=[0][0] from the next cycle. Latency from done_rise edge to first valid is 1 cycle.
- STREAM:
  - valid_o=1, data_o=snapshot[row][col], last_o=(row==N-1 && col==N-1).
  - On handshake (valid_o && ready_i):
    - If col==N-1, col wraps to 0 and row increments; otherwise col increments.
    - On the last handshake, go to IDLE and drop valid_o the next cycle.
  - With ready_i low, data_o, last_o and valid_o hold stable. valid_o never deasserts without a handshake.
- busy_o = (state==STREAM).
- Simultaneous events:
  - A done_rise in the same cycle as the last handshake is captured: the FSM stays in STREAM with counters=0 and the new snapshot, with no bubble cycle.
  - A done_rise at any other point in STREAM is dropped. It sets overrun_o, which stays set until reset. The current snapshot is unaffected.
- Throughput: with ready_i tied high, one element per cycle, so N*N cycles of valid_o per matrix.
- No arithmetic: elements pass bit-exact, with no truncation or extension.

Optional Feature:
Macro STREAM_INDEX_EN.
- When defined: adds outputs row_o and col_o, each $clog2(N) bits wide, equal to the row and col of the current data_o. They are valid whenever valid_o is high, hold under backpressure, and reset to 0.
- When undefined: the ports do not exist and the behaviour is otherwise identical.

Decomposition:
- Shared package (systolic_pkg) holds:
  - default N and ACC_W;
  - an index-width function (clog2 of N);
  - a state enum {IDLE, STREAM}.
  The array and its benches reuse the same defaults.
- One natural sub-module, rc_counter: a row/col wrap counter with clear and advance inputs, and a last output at (N-1, N-1).

Test Plan:
- Capture and stream: N=4, result rows {86,41,230,257},{184,134,288,414},{125,84,340,409},{346,147,344,431}, ready_i=1, done_i raised and held.
  -> Exactly 16 beats in row-major order, 86 first and 431 last. last_o only on 431. valid_o high for 16 consecutive cycles, starting 1 cycle after the done edge.
- Backpressure: same data, ready_i toggling 1-0-0-1 repeatedly.
  -> Data and last_o hold while ready_i=0. Order is unchanged, and 16 handshakes occur in total.
- Overrun: a second done_rise with result_i all 7s arriving during beat 5.
  -> overrun_o=1 sticky; the remaining beats still come from the first matrix; the FSM returns to IDLE after 16 beats.
- Back-to-back: a second done_rise with all-7s data in the same cycle as the 16th handshake.
  -> The next cycle shows valid_o=1 with data_o=7, no gap; overrun_o stays 0.
- Reset mid-stream: assert rst_i after beat 3.
  -> The next cycle shows valid_o=0, busy_o=0, overrun_o=0. A later done_rise restarts from element [0][0].
- Held done: keep done_i high through and after one full drain.
  -> Only one 16-beat burst; no re-capture.
